// File: rtl/sys_array_pkg.sv
// sys_array_pkg -- shared types and default sizing for the systolic-array
// sequencer slice.
//   seq_state_t     : sequencer phase encoding (IDLE, LOAD, FEED, DRAIN, DONE)
//   DEF_DATA_WIDTH  : default width of one weight/input element
//   DEF_ARRAY_SIZE  : default array dimension N (N x N cells)
//   DEF_ROWS_W      : default width of the job row-count operand
package sys_array_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_ROWS_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sys_array_skew.sv
// sys_array_skew -- per-lane delay line that builds the diagonal wavefront
// entering the systolic array. Lane i is delayed by exactly i cycles, so
// lane 0 is a combinational pass-through.
// Ports:
//   clk      in   clock, posedge
//   reset_n  in   synchronous active-low clear of every delay stage
//   din      in   LANES*WIDTH  unskewed row, lane i at [i*WIDTH +: WIDTH]
//   dout     out  LANES*WIDTH  skewed row
module sys_array_skew
  import sys_array_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int LANES = DEF_ARRAY_SIZE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[WIDTH-1:0] = din[WIDTH-1:0];
    end else begin : g_dly
      logic [WIDTH-1:0] pipe [i];

      // Shift this lane's element through i stages; a reset empties the
      // whole line so no stale data reaches the array after an abort.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int k = 0; k < i; k++) begin
            pipe[k] <= '0;
          end
        end else begin
          pipe[0] <= din[i*WIDTH +: WIDTH];
          for (int k = 1; k < i; k++) begin
            pipe[k] <= pipe[k-1];
          end
        end
      end

      assign dout[i*WIDTH +: WIDTH] = pipe[i-1];
    end
  end

endmodule

// File: rtl/sys_array_seq.sv
// sys_array_seq -- job sequencer for an N x N weight-stationary systolic array.
// A job loads N weight rows, streams rows_num input rows through a skew line,
// drains the array for 2N-1 cycles and pulses done.
// Ports:
//   clk, reset_n              clock (posedge) and synchronous active-low reset
//   start, rows_num           begin a job (IDLE only); row count captured with start
//   busy, done                busy outside IDLE; one-cycle done at job end
//   param_valid/param_ready   weight-row handshake, param_row carries the row
//   param_load, param_data    weight-load strobe and row to the array top edge
//   data_valid/data_ready     input-row handshake, data_row carries the row
//   array_in                  skewed input row (lane i delayed i cycles)
//   res_valid                 bit j marks a valid result on array column j
//   busy_cycles               (only with SYS_ARRAY_SEQ_PERF_EN) saturating
//                             count of cycles from start acceptance to DONE
module sys_array_seq
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ROWS_W     = DEF_ROWS_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [ROWS_W-1:0]              rows_num,
  output logic                           busy,
  output logic                           done,
  input  logic                           param_valid,
  output logic                           param_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] param_row,
  output logic                           param_load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] param_data,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_row,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_in,
  output logic [ARRAY_SIZE-1:0]          res_valid
`ifdef SYS_ARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]                    busy_cycles
`endif
);

  localparam int ROW_BITS = ARRAY_SIZE * DATA_WIDTH;
  localparam int BEAT_W   = $clog2(ARRAY_SIZE) + 1;
  localparam int DRAIN_W  = $clog2(2 * ARRAY_SIZE);
  localparam int VLD_LEN  = 2 * ARRAY_SIZE - 1;

  seq_state_t          state_q, state_d;
  logic [ROWS_W-1:0]   rows_left_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic [VLD_LEN-1:0]  vld_sr;
  logic                param_acc;
  logic                data_acc;
  logic                last_beat;
  logic                last_row;
  logic                last_drain;
  logic [ROW_BITS-1:0] skew_in;

  // Handshakes are only honoured in the phase that owns them, so a valid on
  // the other channel is silently ignored.
  assign param_acc  = (state_q == ST_LOAD) && param_valid;
  assign data_acc   = (state_q == ST_FEED) && data_valid;
  assign last_beat  = param_acc && (beat_cnt_q == BEAT_W'(ARRAY_SIZE - 1));
  assign last_row   = data_acc && (rows_left_q == ROWS_W'(1));
  assign last_drain = (drain_cnt_q == DRAIN_W'(2 * ARRAY_SIZE - 2));

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign param_ready = (state_q == ST_LOAD);
  assign data_ready  = (state_q == ST_FEED);
  assign param_load  = param_acc;
  assign param_data  = param_acc ? param_row : '0;
  assign skew_in     = data_acc ? data_row : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-row job skips straight from LOAD to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (last_beat) state_d = (rows_left_q == '0) ? ST_DONE : ST_FEED;
      ST_FEED:  if (last_row) state_d = ST_DRAIN;
      ST_DRAIN: if (last_drain) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Job counters. Rows count down from the latched value so the maximum
  // row count never needs a counter wider than ROWS_W.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_left_q <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_left_q <= rows_num;
          end
          beat_cnt_q  <= '0;
          drain_cnt_q <= '0;
        end
        ST_LOAD: begin
          if (param_acc) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
          end
        end
        ST_FEED: begin
          if (data_acc) begin
            rows_left_q <= rows_left_q - ROWS_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
        end
        default: begin
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  // Accepted-beat flags ride a plain shift register; vld_sr[k] is the flag
  // delayed k+1 cycles, so column j taps the flag delayed N+j cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= data_acc;
      for (int k = 1; k < VLD_LEN; k++) begin
        vld_sr[k] <= vld_sr[k-1];
      end
    end
  end

  // Column taps of the valid pipeline.
  always_comb begin
    res_valid = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      res_valid[j] = vld_sr[ARRAY_SIZE + j - 1];
    end
  end

  sys_array_skew #(
    .WIDTH (DATA_WIDTH),
    .LANES (ARRAY_SIZE)
  ) u_skew (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (skew_in),
    .dout    (array_in)
  );

`ifdef SYS_ARRAY_SEQ_PERF_EN
  // Busy-cycle counter: cleared when a job is accepted, counts every busy
  // cycle (so the final value includes the DONE cycle), then holds in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_cycles <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != '1)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_array_seq.sv
// tb_sys_array_seq -- self-checking bench for sys_array_seq (N=4, DW=8).
// A phase-level reference model plus cycle-indexed history of accepted rows
// predicts every output each cycle; directed jobs add literal expectations
// for latency, strobe counts and skew positions.
// Honours SYS_ARRAY_SEQ_PERF_EN to connect and check busy_cycles.
module tb_sys_array_seq;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int RW   = 8;
  localparam int W    = N * DW;
  localparam int HIST = 4096;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FEED  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] rows_num = '0;
  logic          busy, done;
  logic          param_valid = 1'b0;
  logic          param_ready;
  logic [W-1:0]  param_row = '0;
  logic          param_load;
  logic [W-1:0]  param_data;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [W-1:0]  data_row = '0;
  logic [W-1:0]  array_in;
  logic [N-1:0]  res_valid;
`ifdef SYS_ARRAY_SEQ_PERF_EN
  logic [31:0]   busy_cycles;
`endif

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model state
  int           cyc = 0;
  int           m_phase = M_IDLE;
  int           m_rows, m_wleft, m_rleft, m_dleft;
  logic [31:0]  m_bc = '0;
  bit           hist_acc  [HIST];
  logic [W-1:0] hist_data [HIST];
  logic [W-1:0] obs_ai    [HIST];
  logic [N-1:0] obs_rv    [HIST];
  bit           obs_busy  [HIST];
  bit           m_acc;
  logic [W-1:0] exp_ai;
  logic [N-1:0] exp_rv;
  int           pl_cnt, dr_cnt, rv_cnt;

  always #5 clk = ~clk;

  sys_array_seq #(
    .DATA_WIDTH (DW),
    .ARRAY_SIZE (N),
    .ROWS_W     (RW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .rows_num    (rows_num),
    .busy        (busy),
    .done        (done),
    .param_valid (param_valid),
    .param_ready (param_ready),
    .param_row   (param_row),
    .param_load  (param_load),
    .param_data  (param_data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_row    (data_row),
    .array_in    (array_in),
    .res_valid   (res_valid)
`ifdef SYS_ARRAY_SEQ_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model advance: job phases from the rules (weights, rows, 2N-1 drain).
  always @(posedge clk) begin
    if (reset_n !== 1'b1) begin
      m_phase = M_IDLE;
      m_bc = '0;
      for (int i = 0; i < HIST; i++) begin
        hist_acc[i] = 1'b0;
        hist_data[i] = '0;
      end
    end else begin
      if ((m_phase == M_IDLE) && (start === 1'b1)) m_bc = '0;
      else if ((m_phase != M_IDLE) && (m_bc != 32'hFFFF_FFFF)) m_bc = m_bc + 32'd1;
      case (m_phase)
        M_IDLE: if (start === 1'b1) begin
          m_phase = M_LOAD;
          m_rows = int'(rows_num);
          m_wleft = N;
        end
        M_LOAD: if (param_valid === 1'b1) begin
          m_wleft--;
          if (m_wleft == 0) begin
            m_phase = (m_rows == 0) ? M_DONE : M_FEED;
            m_rleft = m_rows;
          end
        end
        M_FEED: if (data_valid === 1'b1) begin
          m_rleft--;
          if (m_rleft == 0) begin
            m_phase = M_DRAIN;
            m_dleft = 2 * N - 1;
          end
        end
        M_DRAIN: begin
          m_dleft--;
          if (m_dleft == 0) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
    cyc++;
  end

  // Compare process: every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    if (check_en && (cyc < HIST)) begin
      m_acc = (m_phase == M_FEED) && (data_valid === 1'b1);
      hist_acc[cyc] = m_acc;
      hist_data[cyc] = m_acc ? data_row : '0;
      exp_ai = '0;
      exp_rv = '0;
      for (int i = 0; i < N; i++) begin
        if (cyc - i >= 0) exp_ai[i*DW +: DW] = hist_data[cyc-i][i*DW +: DW];
      end
      for (int j = 0; j < N; j++) begin
        if (cyc - N - j >= 0) exp_rv[j] = hist_acc[cyc-N-j];
      end
      checkOutput("busy", busy, m_phase != M_IDLE);
      checkOutput("done", done, m_phase == M_DONE);
      checkOutput("param_ready", param_ready, m_phase == M_LOAD);
      checkOutput("data_ready", data_ready, m_phase == M_FEED);
      checkOutput("param_load", param_load, (m_phase == M_LOAD) && (param_valid === 1'b1));
      checkOutput("param_data", param_data,
                  ((m_phase == M_LOAD) && (param_valid === 1'b1)) ? param_row : '0);
      checkOutput("array_in", array_in, exp_ai);
      checkOutput("res_valid", res_valid, exp_rv);
`ifdef SYS_ARRAY_SEQ_PERF_EN
      checkOutput("busy_cycles", busy_cycles, m_bc);
`endif
      obs_ai[cyc] = array_in;
      obs_rv[cyc] = res_valid;
      obs_busy[cyc] = busy;
      if (param_load === 1'b1) pl_cnt++;
      if (data_ready === 1'b1) dr_cnt++;
      if (res_valid !== '0) rv_cnt++;
    end
  end

  task automatic startJob(input int rows, output int s);
    start = 1'b1;
    rows_num = RW'(rows);
    s = cyc;
    pl_cnt = 0;
    dr_cnt = 0;
    rv_cnt = 0;
    step();
    start = 1'b0;
  endtask

  task automatic loadWeights(input int stall, input bit noise);
    int sent = 0;
    int st = stall;
    int g = 0;
    start = noise;
    data_valid = noise;
    data_row = 32'hCAFEF00D;
    while (sent < N && g < 100) begin
      if (sent == 2 && st > 0) begin
        param_valid = 1'b0;
        st--;
      end else begin
        param_valid = 1'b1;
        param_row = 32'hA0B0C0D0 + sent;
        sent++;
      end
      step();
      g++;
    end
    param_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic feedRows(input int rows, input int bubble, input bit noise);
    int sent = 0;
    int bub = bubble;
    int g = 0;
    param_valid = noise;
    param_row = 32'hDEADBEEF;
    while (sent < rows && g < 1000) begin
      if (sent == 1 && bub > 0) begin
        data_valid = 1'b0;
        data_row = 32'h5A5A5A5A;
        bub--;
      end else begin
        data_valid = 1'b1;
        data_row = (sent == 0) ? 32'h07020305 : 32'h11223344 + sent;
        sent++;
      end
      step();
      g++;
    end
    data_valid = 1'b0;
    param_valid = 1'b0;
  endtask

  task automatic waitDone(input bit noise, output int done_cyc);
    int g = 0;
    bit seen = 1'b0;
    done_cyc = -1;
    if (noise) begin
      start = 1'b1;
      data_valid = 1'b1;
      param_valid = 1'b1;
    end
    while (!seen && g < 400) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
      g++;
    end
    checkOutput("done_seen", seen, 1);
    step();
    start = 1'b0;
    data_valid = 1'b0;
    param_valid = 1'b0;
  endtask

  // One full job with optional weight stall, data bubble and off-phase noise.
  task automatic applyStimulus(input int rows, input int stall, input int bubble,
                               input bit noise, output int s, output int d);
    startJob(rows, s);
    loadWeights(stall, noise);
    if (rows > 0) feedRows(rows, bubble, noise);
    waitDone(noise, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, d, a, low;
    step();
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_array_in", array_in, 0);
    step();
    reset_n = 1'b1;
    step();

    // Clean job, rows=3: done 15 cycles after start, skew positions pinned.
    applyStimulus(3, 0, 0, 1'b0, s, d);
    checkOutput("lat_rows3", d - s, 15);
    low = 0;
    for (int k = s + 1; k <= d; k++) if (!obs_busy[k]) low++;
    checkOutput("busy_held", low, 0);
    a = s + 5;
    checkOutput("lane0_beat0", obs_ai[a][7:0], 8'd5);
    checkOutput("lane3_at_accept", obs_ai[a][31:24], 8'd0);
    checkOutput("lane3_beat0", obs_ai[a+3][31:24], 8'd7);
    checkOutput("res_valid2_early", obs_rv[a+5][2], 0);
    checkOutput("res_valid2_beat0", obs_rv[a+6][2], 1);
`ifdef SYS_ARRAY_SEQ_PERF_EN
    checkOutput("perf_rows3", busy_cycles, 15);
`endif

    // Weight stall of 2 cycles with cross-channel noise.
    applyStimulus(2, 2, 0, 1'b1, s, d);
    checkOutput("lat_stall", d - s, 16);
    checkOutput("param_load_pulses", pl_cnt, 4);

    // Zero-row job: LOAD then DONE, never data_ready, no results.
    applyStimulus(0, 0, 0, 1'b1, s, d);
    checkOutput("lat_rows0", d - s, 5);
    checkOutput("rows0_data_ready", dr_cnt, 0);
    checkOutput("rows0_res_valid", rv_cnt, 0);

    // Reset during FEED, then a fresh job.
    startJob(5, s);
    loadWeights(0, 1'b0);
    feedRows(2, 0, 1'b0);
    reset_n = 1'b0;
    data_valid = 1'b1;
    step();
    reset_n = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_array_in", array_in, 0);
    checkOutput("abort_res_valid", res_valid, 0);
    step();
    applyStimulus(3, 0, 0, 1'b0, s, d);
    checkOutput("lat_after_abort", d - s, 15);

    // Data bubbles stretch FEED.
    applyStimulus(3, 0, 2, 1'b0, s, d);
    checkOutput("lat_bubble", d - s, 17);

    // Maximum row count completes without wrap.
    applyStimulus(255, 0, 0, 1'b0, s, d);
    checkOutput("lat_rows255", d - s, 267);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_array_seq.md
SYS_ARRAY_SEQ -- requirements
Module: sys_array_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one weight/input element.
REQ-002 Parameter ARRAY_SIZE, default 4, array dimension N (N x N cells).
REQ-003 Parameter ROWS_W, default 8, width of row-count operand.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  begin one job; sampled only in IDLE.
REQ-007 rows_num  in  ROWS_W  input rows in job; captured with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at job end.
REQ-010 param_valid / param_ready  in / out  1 / 1  weight-row handshake.
REQ-011 param_row  in  N*DATA_WIDTH  one weight row, lane i at bits [i*DW +: DW].
REQ-012 param_load  out  1  array weight-load strobe.
REQ-013 param_data  out  N*DATA_WIDTH  weight row to array top edge.
REQ-014 data_valid / data_ready  in / out  1 / 1  input-row handshake.
REQ-015 data_row  in  N*DATA_WIDTH  one input row.
REQ-016 array_in  out  N*DATA_WIDTH  skewed input to array; lane i delayed i cycles.
REQ-017 res_valid  out  N  bit j marks valid result on array column j.

Function
REQ-018 States: IDLE, LOAD, FEED, DRAIN, DONE.
REQ-019 IDLE->LOAD when start=1; rows_num latched same cycle.
REQ-020 LOAD: param_ready=1; param_load=1 and param_data=param_row exactly on accepted beats (valid&ready); stall cycles drive param_load=0, param_data=0.
REQ-021 LOAD->FEED after N accepted beats; if latched rows_num=0, LOAD->DONE instead.
REQ-022 FEED: data_ready=1; each accepted beat enters skew line; non-accepted cycles inject zeros (bubble).
REQ-023 FEED->DRAIN on acceptance of beat number rows_num.
REQ-024 DRAIN lasts exactly 2N-1 cycles, zeros injected, then ->DONE.
REQ-025 DONE: done=1 one cycle, ->IDLE; start in DONE ignored.
REQ-026 res_valid[j] = accepted-beat flag delayed N+j cycles; bubbles produce 0.
REQ-027 param_ready=0 outside LOAD; data_ready=0 outside FEED; start ignored when busy.
REQ-028 Row counter ROWS_W bits, no wrap: rows_num=2^ROWS_W-1 completes normally.
REQ-029 Simultaneous param_valid and data_valid: only the one matching current state is accepted.

Reset
REQ-030 reset_n=0 at any clock, including mid-job: state=IDLE, counters=0, skew and valid pipelines cleared, all outputs 0, no done pulse.

Configuration
REQ-031 SYS_ARRAY_SEQ_PERF_EN defined: extra output busy_cycles (32 bits) counts cycles from start acceptance through DONE inclusive, holds until next start, saturates at all-ones, reset to 0.
REQ-032 SYS_ARRAY_SEQ_PERF_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-033 Package sys_array_pkg holds the state enum type and default parameter constants.
REQ-034 Sub-module sys_array_skew: per-lane delay line (lane i delayed i cycles, synchronous clear), instantiated for array_in; res_valid uses a plain shift register.

Verification
REQ-035 N=4, rows_num=3, no stalls: done exactly 4+3+7+1 cycles after start; busy high throughout.
REQ-036 param_valid low 2 cycles mid-LOAD: exactly 4 param_load pulses, data unchanged on stall cycles.
REQ-037 data_row lane0=5, lane3=7 on beat 0: array_in lane0=5 cycle+0, lane3=7 cycle+3; res_valid[2] high 6 cycles after accept.
REQ-038 rows_num=0: LOAD then DONE; no data_ready, res_valid always 0.
REQ-039 reset_n low during FEED: next cycle IDLE, outputs 0, fresh job completes correctly.
REQ-040 With SYS_ARRAY_SEQ_PERF_EN, REQ-035 job: busy_cycles=15 after done.
